// File: rtl/load_store_unit.sv
// RV32I memory stage: turns one decoded LOAD/STORE into a req/gnt/rvalid bus transaction
// and returns a single aligned/extended result per request.
module load_store_unit #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_misalign,
    output logic        resp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [9:0] LimitM1 = 10'(WAIT_LIMIT - 1);

    state_e      state_q, state_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d, resp_mis_q, resp_mis_d, resp_err_q, resp_err_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic        req_bad;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_shift, ld_data;

    // Request decode: illegal funct3 or misaligned address, plus store lane placement.
    always_comb begin
        req_bad = 1'b0;
        if (req_load) begin
            if (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11) req_bad = 1'b1;
        end else if (req_funct3 > 3'd2) begin
            req_bad = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_bad = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;

        case (req_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {req_addr[1], 1'b0};
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        ld_shift = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    ld_data = {24'd0, ld_shift[7:0]};
            3'd5:    ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_mis_d   = 1'b0;
        resp_err_d   = 1'b0;
        resp_rd_d    = 5'd0;
        resp_data_d  = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    is_load_d = req_load;
                    funct3_d  = req_funct3;
                    off_d     = req_addr[1:0];
                    rd_d      = req_rd;
                    if (req_bad) begin
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                    end else begin
                        state_d     = StIssue;
                        cnt_d       = 10'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~req_load;
                        mem_be_d    = req_load ? 4'b1111 : st_be;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_load ? 32'd0 : st_wdata;
                    end
                end
            end
            StIssue: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (is_load_q) begin
                        state_d = StWait;
                        cnt_d   = 10'd0;
                    end else begin
                        state_d      = StIdle;
                        resp_valid_d = 1'b1;
                    end
                end else if (cnt_q == LimitM1) begin
                    state_d      = StIdle;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    resp_data_d  = ld_data;
                end else if (cnt_q == LimitM1) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            cnt_q        <= 10'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= 5'd0;
            resp_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_mis_q   <= resp_mis_d;
            resp_err_q   <= resp_err_d;
            resp_rd_q    <= resp_rd_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready     = (state_q == StIdle);
    assign resp_valid    = resp_valid_q;
    assign resp_rd       = resp_rd_q;
    assign resp_data     = resp_data_q;
    assign resp_misalign = resp_mis_q;
    assign resp_err      = resp_err_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_be        = mem_be_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
endmodule
